instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Consumer side of the program-counter interface: takes the 3-bit address issued by the program counter, reads the addressed instruction from an internal 8-entry program memory, and presents the decoded instruction to the execute stage.
- Uses a valid/ready handshake on both sides.
- Holds a halt state once a HLT instruction is consumed.
- Sits between the program counter and the ALU/register-file control in the 4-bit processor.

## Interface

Parameters:
- ADDR_W, 3, instruction address width (8 entries)
- INSTR_W, 8, instruction width
- OPC_W, 4, opcode field width (operand = INSTR_W-OPC_W)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- pc_in  in  ADDR_W  fetch address from program counter
- pc_valid  in  1  pc_in is valid
- pc_ready  out  1  block accepts an address this cycle
- prog_we  in  1  program-memory write enable
- prog_addr  in  ADDR_W  write address
- prog_data  in  INSTR_W  write data
- instr_valid  out  1  opcode/operand/instr_addr valid
- instr_ready  in  1  execute stage accepts instruction
- opcode  out  OPC_W  instruction bits [7:4]
- operand  out  INSTR_W-OPC_W  instruction bits [3:0]
- instr_addr  out  ADDR_W  address the instruction came from
- halt  out  1  HLT consumed; fetch stopped
- fetch_count  out  4  instructions consumed, saturates at 15

## Operation

- FSM states:
  - IDLE: pc_ready=1. pc_valid&&pc_ready captures pc_in into addr_q → READ.
  - READ: registered memory read of mem[addr_q] into IR; instr_addr<=addr_q → HOLD.
  - HOLD: instr_valid=1; opcode/operand/instr_addr stable until instr_valid&&instr_ready. On accept:
    - fetch_count increments (saturating at 15).
    - opcode==OPC_HLT (4'hF) → HALTED; else → IDLE.
  - HALTED: halt=1, pc_ready=0, instr_valid=0. Leaves only on rst.
- pc_ready is 0 in READ, HOLD and HALTED; pc_valid in those states is ignored, not queued.
- Program writes:
  - Accepted in every state. mem[prog_addr]<=prog_data at the edge.
  - Write in READ to the same address as addr_q: the IR gets prog_data (write-first forwarding).
  - Writes never alter an IR already loaded (HOLD).
- Addresses are 3-bit unsigned; no wrap logic is needed — any value 0..7 is legal.

## Timing

- Reset (rst high at an edge) forces:
  - state=IDLE, addr_q=0, IR=8'h00 (opcode 0, operand 0), instr_addr=0, halt=0, fetch_count=0, instr_valid=0; pc_ready=1 from the next cycle.
  - All 8 memory entries cleared to 8'h00 (NOP); prog_we ignored in that cycle.
- rst dominates every other input in any state, including mid-READ/HOLD/HALTED.
- Latency:
  - Address handshake at edge k → instr_valid high after edge k+1.
  - Accept at edge m → pc_ready high after edge m (IDLE).
  - Minimum 3 cycles per instruction.
- instr_valid, once high, stays high with unchanged outputs until accepted (no retraction).
- fetch_count updates on the accepting edge; at 15 it holds.

## Structure

- Package fetch_pkg: state enum (IDLE, READ, HOLD, HALTED), OPC_HLT=4'hF, OPC_NOP=4'h0, ADDR_W/INSTR_W/OPC_W defaults.
- Sub-module instr_rom: 8×INSTR_W array, synchronous write, registered read with write-first forwarding, synchronous clear on rst.
- Top level holds the FSM, addr_q, the fetch counter and output decode.

## Test plan

- Reset then idle: rst 1 cycle → pc_ready=1, instr_valid=0, halt=0, fetch_count=0. Fetch addr 5 → opcode 0, operand 0.
- Basic fetch:
  - Stimulus: write mem[3]=8'h2A; pc_in=3 with pc_valid; instr_ready=1.
  - Response: instr_valid two edges after the handshake with opcode 2, operand A, instr_addr 3; fetch_count=1.
- Backpressure:
  - Stimulus: same fetch with instr_ready=0 for 4 cycles; pc_valid held high with pc_in=6.
  - Response: outputs stable, pc_ready=0. After accept, the next handshake captures 6.
- Write-first:
  - Stimulus: mem[1]=8'h11; handshake addr 1, then in the READ cycle write mem[1]=8'h7C.
  - Response: opcode 7, operand C.
- Halt:
  - Stimulus: mem[4]=8'hF0; fetch and accept addr 4.
  - Response: halt=1, pc_ready=0. Further pc_valid is ignored for 10 cycles; rst clears halt and memory.
- Saturation and reset mid-operation:
  - Stimulus: 17 fetch/accept pairs of 8'h00.
  - Response: fetch_count=15.
  - Stimulus: rst asserted in HOLD.
  - Response: instr_valid=0, state IDLE next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcodes and FSM states for the instruction fetch stage
package fetch_pkg;
  localparam int ADDR_W = 3;
  localparam int INSTR_W = 8;
  localparam int OPC_W = 4;
  localparam logic [3:0] OPC_HLT = 4'hF;
  localparam logic [3:0] OPC_NOP = 4'h0;
  typedef enum logic [1:0] {IDLE, READ, HOLD, HALTED} state_t;
endpackage

// File: rtl/instr_rom.sv
// instr_rom: 8-entry program memory with registered read into the instruction register
module instr_rom #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] r_mem [2**ADDR_W];
  logic [INSTR_W-1:0] r_ir;
  assign rdata = r_ir;
  // a same-cycle write to the address being read wins over the old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
      r_ir <= '0;
    end else begin
      if (we) r_mem[waddr] <= wdata;
      if (rd_en) r_ir <= (we && waddr == raddr) ? wdata : r_mem[raddr];
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: takes PC addresses, reads program memory and hands decoded instructions to execute
module instruction_fetch #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int OPC_W = fetch_pkg::OPC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [INSTR_W-1:0]       prog_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic [ADDR_W-1:0]        instr_addr,
  output logic                     halt,
  output logic [3:0]               fetch_count
);
  import fetch_pkg::*;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_instr_addr;
  logic [3:0] r_count;
  logic [INSTR_W-1:0] w_ir;
  logic w_accept;
  assign pc_ready = r_state == IDLE;
  assign instr_valid = r_state == HOLD;
  assign halt = r_state == HALTED;
  assign opcode = w_ir[INSTR_W-1:INSTR_W-OPC_W];
  assign operand = w_ir[INSTR_W-OPC_W-1:0];
  assign instr_addr = r_instr_addr;
  assign fetch_count = r_count;
  assign w_accept = instr_valid && instr_ready;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && pc_valid) ? READ :
             (r_state == READ) ? HOLD :
             (w_accept) ? ((opcode == OPC_W'(OPC_HLT)) ? HALTED : IDLE) : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_instr_addr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (pc_ready && pc_valid) r_addr <= pc_in;
      if (r_state == READ) r_instr_addr <= r_addr;
      if (w_accept && r_count != 4'hF) r_count <= r_count + 4'd1;
    end
  end
  instr_rom #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_rom (
    .clk(clk),
    .rst(rst),
    .we(prog_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .rd_en(r_state == READ),
    .raddr(r_addr),
    .rdata(w_ir)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard-driven scenario tests for instruction_fetch
module tb_instruction_fetch;
  logic       clk = 0;
  logic       rst = 1;
  logic [2:0] pc_in = 0;
  logic       pc_valid = 0;
  logic       pc_ready;
  logic       prog_we = 0;
  logic [2:0] prog_addr = 0;
  logic [7:0] prog_data = 0;
  logic       instr_valid;
  logic       instr_ready = 0;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [2:0] instr_addr;
  logic       halt;
  logic [3:0] fetch_count;
  int checks = 0;
  int passed = 0;
  typedef struct packed {logic [3:0] opc; logic [3:0] opr; logic [2:0] addr;} exp_t;
  exp_t sb[$];

  instruction_fetch dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .operand(operand), .instr_addr(instr_addr), .halt(halt), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [7:0] instr);
    pc_in = a; pc_valid = 1;
    sb.push_back({instr[7:4], instr[3:0], a});
    @(negedge clk);
    pc_valid = 0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = instr_valid;
  endtask

  task automatic accept();
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
  endtask

  function automatic exp_t pop_exp();
    exp_t e = '1;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    bit ok;
    exp_t e;
    checks++;
    if ({pc_ready, instr_valid, halt, fetch_count} !== {1'b1, 1'b0, 1'b0, 4'd0})
      $display("FAIL reset_state got rdy=%b vld=%b halt=%b cnt=%0d exp 1 0 0 0", pc_ready, instr_valid, halt, fetch_count);
    else passed++;
    issue(3'd5, 8'h00);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL reset_fetch5 got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
  endtask

  task automatic test_basic();
    exp_t e;
    do_reset();
    write_mem(3'd3, 8'h2A);
    instr_ready = 0;
    issue(3'd3, 8'h2A);
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", instr_valid);
    else passed++;
    @(negedge clk);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || {opcode, operand, instr_addr} !== e)
      $display("FAIL basic_fetch got vld=%b %h/%h@%0d exp 1 %h/%h@%0d", instr_valid, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
    checks++;
    if (fetch_count !== 4'd1 || pc_ready !== 1'b1)
      $display("FAIL basic_count got cnt=%0d rdy=%b exp 1 1", fetch_count, pc_ready);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_t e;
    int bad = 0;
    write_mem(3'd6, 8'h93);
    issue(3'd3, 8'h2A);
    pc_in = 3'd6; pc_valid = 1;
    wait_valid(ok);
    e = pop_exp();
    for (int i = 0; i < 4; i++) begin
      if (!instr_valid || pc_ready || {opcode, operand, instr_addr} !== e) bad++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bad != 0)
      $display("FAIL bp_stable got ok=%b bad_cycles=%0d %h/%h@%0d exp 0 bad %h/%h@%0d", ok, bad, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    instr_ready = 1;
    sb.push_back({4'h9, 4'h3, 3'd6});
    @(negedge clk);
    instr_ready = 0;
    checks++;
    if (pc_ready !== 1'b1) $display("FAIL bp_ready_after_accept got %b exp 1", pc_ready);
    else passed++;
    @(negedge clk);
    pc_valid = 0;
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL bp_next_fetch got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
  endtask

  task automatic test_write_first();
    bit ok;
    exp_t e;
    write_mem(3'd1, 8'h11);
    issue(3'd1, 8'h7C);
    write_mem(3'd1, 8'h7C);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL wf_forward got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    write_mem(3'd1, 8'h33);
    checks++;
    if ({opcode, operand} !== 8'h7C) $display("FAIL wf_hold_write got %h%h exp 7c", opcode, operand);
    else passed++;
    accept();
    issue(3'd1, 8'h33);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL wf_refetch got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
  endtask

  task automatic test_halt();
    bit ok;
    exp_t e;
    int bad = 0;
    write_mem(3'd4, 8'hF0);
    issue(3'd4, 8'hF0);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL halt_fetch got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
    checks++;
    if ({halt, pc_ready, instr_valid} !== 3'b100)
      $display("FAIL halt_state got halt=%b rdy=%b vld=%b exp 1 0 0", halt, pc_ready, instr_valid);
    else passed++;
    pc_in = 3'd3; pc_valid = 1; instr_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({halt, pc_ready, instr_valid} !== 3'b100) bad++;
    end
    pc_valid = 0; instr_ready = 0;
    checks++;
    if (bad != 0) $display("FAIL halt_sticky got bad_cycles=%0d exp 0", bad);
    else passed++;
    @(negedge clk);
    rst = 1; prog_we = 1; prog_addr = 3'd2; prog_data = 8'h55;
    @(negedge clk);
    rst = 0; prog_we = 0;
    sb.delete();
    checks++;
    if ({halt, pc_ready, fetch_count} !== {1'b0, 1'b1, 4'd0})
      $display("FAIL halt_reset got halt=%b rdy=%b cnt=%0d exp 0 1 0", halt, pc_ready, fetch_count);
    else passed++;
    issue(3'd4, 8'h00);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL halt_mem_cleared got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
    issue(3'd2, 8'h00);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL halt_we_in_reset got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
  endtask

  task automatic test_saturation();
    bit ok;
    exp_t e;
    int bad = 0;
    logic [3:0] exp_cnt = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(3'(i), 8'h00);
      wait_valid(ok);
      e = pop_exp();
      if (!ok || {opcode, operand, instr_addr} !== e) bad++;
      accept();
      exp_cnt = (exp_cnt == 4'hF) ? exp_cnt : exp_cnt + 4'd1;
      if (fetch_count !== exp_cnt) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL sat_sequence got bad=%0d exp 0", bad);
    else passed++;
    checks++;
    if (fetch_count !== 4'd15) $display("FAIL sat_count got %0d exp 15", fetch_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_t e;
    write_mem(3'd2, 8'hA5);
    issue(3'd2, 8'hA5);
    wait_valid(ok);
    checks++;
    if (!ok || {opcode, operand} !== 8'hA5) $display("FAIL mid_hold got ok=%b %h%h exp a5", ok, opcode, operand);
    else passed++;
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    checks++;
    if ({instr_valid, pc_ready, fetch_count, opcode, operand} !== {1'b0, 1'b1, 4'd0, 8'h00})
      $display("FAIL mid_reset got vld=%b rdy=%b cnt=%0d ir=%h%h exp 0 1 0 00", instr_valid, pc_ready, fetch_count, opcode, operand);
    else passed++;
    issue(3'd2, 8'h00);
    wait_valid(ok);
    e = pop_exp();
    checks++;
    if (!ok || {opcode, operand, instr_addr} !== e)
      $display("FAIL mid_refetch got ok=%b %h/%h@%0d exp %h/%h@%0d", ok, opcode, operand, instr_addr, e.opc, e.opr, e.addr);
    else passed++;
    accept();
  endtask

  initial begin
    @(negedge clk);
    rst = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_write_first();
    test_halt();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
